// File: rtl/spi_master_ctrl_if.sv
// ============================================================================
// Module      : spi_master_ctrl_if
// Description : Host-side request/response bundle for the SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_master_ctrl_if #(
  parameter int DATA_W   = 128,
  parameter int CS_SEL_W = 1
) ();
  logic                start;
  logic [CS_SEL_W-1:0] cs_sel;
  logic                cpol;
  logic                cpha;
  logic [DATA_W-1:0]   tx_data;
  logic [DATA_W-1:0]   rx_data;
  logic                busy;
  logic                done;

  modport master (
    output start, cs_sel, cpol, cpha, tx_data,
    input  rx_data, busy, done
  );

  modport slave (
    input  start, cs_sel, cpol, cpha, tx_data,
    output rx_data, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// ============================================================================
// Module      : spi_master_ctrl
// Description : Full-duplex SPI master, configurable width/divider/mode/CS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_ctrl #(
  parameter int DATA_W   = 128,
  parameter int NUM_CS   = 2,
  parameter int CS_SEL_W = 1,
  parameter int CLK_DIV  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  spi_master_ctrl_if.slave       bus,
  output      logic              sclk,
  output      logic [NUM_CS-1:0] cs_n,
  output      logic              mosi,
  input  wire logic              miso
);

  localparam int EDGES  = 2 * DATA_W;
  localparam int EDGE_W = $clog2(EDGES + 1);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SETUP = 2'd1;
  localparam logic [1:0] c_XFER  = 2'd2;
  localparam logic [1:0] c_HOLD  = 2'd3;

  localparam logic [EDGE_W-1:0] c_LAST_EDGE = EDGE_W'(EDGES - 1);
  localparam logic [DIV_W-1:0]  c_DIV_END   = DIV_W'(CLK_DIV - 1);

  logic [1:0]        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [EDGE_W-1:0] r_edge;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_busy;
  logic              r_done;
  logic              r_sclk;
  logic              r_mosi;
  logic [NUM_CS-1:0] r_cs_n;

  logic              w_div_end;
  logic              w_sample;
  logic              w_last;
  logic              w_sel_ok;
  logic [NUM_CS-1:0] w_cs_dec;

  assign w_div_end = (r_div == c_DIV_END);
  assign w_last    = (r_edge == c_LAST_EDGE);
  // Even edge count means the upcoming edge is a leading one.
  assign w_sample  = (~r_edge[0]) ^ r_cpha;
  assign w_sel_ok  = ({1'b0, bus.cs_sel} < (CS_SEL_W + 1)'(NUM_CS));

  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (bus.cs_sel == CS_SEL_W'(i)) w_cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_div     <= '0;
      r_edge    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_busy <= 1'b0;
          r_cs_n <= '1;
          r_sclk <= bus.cpol;
          r_div  <= '0;
          r_edge <= '0;
          // r_busy is still high on the done cycle, which blocks re-accept there.
          if (bus.start && !r_busy && w_sel_ok) begin
            r_state <= c_SETUP;
            r_busy  <= 1'b1;
            r_cs_n  <= w_cs_dec;
            r_cpol  <= bus.cpol;
            r_cpha  <= bus.cpha;
            r_tx    <= bus.tx_data;
            r_rx    <= '0;
            if (!bus.cpha) r_mosi <= bus.tx_data[DATA_W-1];
          end
        end
        c_SETUP, c_XFER: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_sclk  <= ~r_sclk;
            r_edge  <= r_edge + 1'b1;
            r_state <= w_last ? c_HOLD : c_XFER;
            if (w_sample) begin
              r_rx <= {r_rx[DATA_W-2:0], miso};
            end else if (r_cpha) begin
              r_mosi <= r_tx[DATA_W-1];
              r_tx   <= r_tx << 1;
            end else if (!w_last) begin
              r_mosi <= r_tx[DATA_W-2];
              r_tx   <= r_tx << 1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        c_HOLD: begin
          r_sclk <= r_cpol;
          if (w_div_end) begin
            r_div     <= '0;
            r_state   <= c_IDLE;
            r_done    <= 1'b1;
            r_cs_n    <= '1;
            r_rx_data <= r_rx;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign sclk        = r_sclk;
  assign cs_n        = r_cs_n;
  assign mosi        = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// ============================================================================
// Module      : tb_spi_master_ctrl
// Description : Scoreboard bench: 8-bit/div-2 instance plus 128-bit/div-1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_ctrl;

  typedef struct {
    logic [127:0] rx;
    logic [7:0]   srx;
    bit           chk_s;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: 8-bit frames, divider 2, two chip selects
  logic       sclk_a, mosi_a, miso_a;
  logic [1:0] cs_a;
  logic       loop_a = 1'b1;
  logic       s_miso = 1'b0;
  spi_master_ctrl_if #(.DATA_W(8), .CS_SEL_W(1)) a_bus ();
  spi_master_ctrl #(.DATA_W(8), .NUM_CS(2), .CS_SEL_W(1), .CLK_DIV(2)) u_a (
    .clk(clk), .rst(rst_a), .bus(a_bus.slave),
    .sclk(sclk_a), .cs_n(cs_a), .mosi(mosi_a), .miso(miso_a)
  );
  assign miso_a = loop_a ? mosi_a : s_miso;

  // Instance B: AES-block frames, divider 1, 2-bit select with two slaves
  logic       sclk_b, mosi_b;
  logic [1:0] cs_b;
  spi_master_ctrl_if #(.DATA_W(128), .CS_SEL_W(2)) b_bus ();
  spi_master_ctrl #(.DATA_W(128), .NUM_CS(2), .CS_SEL_W(2), .CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst_b), .bus(b_bus.slave),
    .sclk(sclk_b), .cs_n(cs_b), .mosi(mosi_b), .miso(mosi_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural SPI slave on instance A: returns 0x3C, captures what it receives.
  logic       m_cpol = 1'b0, m_cpha = 1'b0;
  logic [7:0] s_rx = 8'h00;
  initial begin : slave_model
    logic [7:0] s_tx;
    logic       s_act, s_prev, act, lead;
    int         s_idx;
    s_tx = 8'h3C; s_act = 1'b0; s_prev = 1'b0; s_idx = 0;
    forever begin
      @(negedge clk);
      act = (cs_a != 2'b11);
      if (act && !s_act) begin
        s_rx  = 8'h00;
        s_idx = 0;
        if (!m_cpha) begin
          s_miso = s_tx[7];
          s_idx  = 1;
        end
      end else if (act && (sclk_a != s_prev)) begin
        lead = (sclk_a != m_cpol);
        if (lead ^ m_cpha) begin
          s_rx = {s_rx[6:0], mosi_a};
        end else if (s_idx < 8) begin
          s_miso = s_tx[7 - s_idx];
          s_idx++;
        end
      end
      s_act  = act;
      s_prev = sclk_a;
    end
  end

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_bus.done === 1'b1) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_done_unexpected actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = qa.pop_front();
          check("a_rx_data", a_bus.rx_data, e.rx);
          check("a_done_cycle", cyc, e.cyc);
          if (e.chk_s) check("a_slave_rx", s_rx, e.srx);
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (b_bus.done === 1'b1) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_done_unexpected actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = qb.pop_front();
          check("b_rx_data", b_bus.rx_data, e.rx);
          check("b_done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One frame on A with cycle-by-cycle pin checks and mid-frame input scrambling.
  task automatic frame_a(input logic [7:0] tx, input logic sel, input logic pol, input logic pha,
                         input logic loop, input logic [7:0] exp_rx, input bit chk_s);
    int         t0, n;
    logic [1:0] dec;
    exp_t       e;
    dec = sel ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    a_bus.cpol = pol; a_bus.cpha = pha; a_bus.cs_sel = sel; a_bus.tx_data = tx;
    m_cpol = pol; m_cpha = pha; loop_a = loop;
    @(posedge clk); @(negedge clk);
    check("a_sclk_idle_before", sclk_a, pol);
    @(posedge clk); #1;
    a_bus.start = 1'b1;
    t0 = cyc;
    e.rx = {120'd0, exp_rx}; e.srx = tx; e.chk_s = chk_s; e.cyc = t0 + 35;
    qa.push_back(e);
    for (int r = 1; r <= 37; r++) begin
      @(posedge clk); #1;
      if (r == 1) begin
        a_bus.start = 1'b0;
        a_bus.tx_data = ~tx; a_bus.cs_sel = ~sel; a_bus.cpol = ~pol; a_bus.cpha = ~pha;
      end
      if (r == 30) begin
        a_bus.tx_data = tx; a_bus.cs_sel = sel; a_bus.cpol = pol; a_bus.cpha = pha;
      end
      @(negedge clk);
      n = (r >= 3) ? (((r - 1) / 2 > 16) ? 16 : (r - 1) / 2) : 0;
      check("a_cs_n_t", cs_a, (r <= 34) ? dec : 2'b11);
      check("a_sclk_t", sclk_a, pol ^ n[0]);
      check("a_busy_t", a_bus.busy, (r <= 35) ? 1'b1 : 1'b0);
    end
    check("a_sclk_idle_after", sclk_a, pol);
  endtask

  initial begin : stim
    int   t0;
    exp_t e;
    logic [127:0] aes;
    aes = 128'h00112233445566778899AABBCCDDEEFF;
    a_bus.start = 1'b0; a_bus.cs_sel = 1'b0; a_bus.cpol = 1'b0; a_bus.cpha = 1'b0; a_bus.tx_data = 8'h00;
    b_bus.start = 1'b0; b_bus.cs_sel = 2'd0; b_bus.cpol = 1'b0; b_bus.cpha = 1'b0; b_bus.tx_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_cs_n", cs_a, 2'b11);
    check("a_rst_sclk", sclk_a, 1'b0);
    check("a_rst_mosi", mosi_a, 1'b0);
    check("a_rst_busy", a_bus.busy, 1'b0);
    check("a_rst_done", a_bus.done, 1'b0);
    check("a_rst_rx", a_bus.rx_data, 8'h00);
    check("b_rst_cs_n", cs_b, 2'b11);
    check("b_rst_rx", b_bus.rx_data, 128'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Mode 0 loopback, then the slave model in modes 3, 1, 2
    frame_a(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
    frame_a(8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1);
    frame_a(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1);
    frame_a(8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1);

    // Starts at 0, 10 and the done cycle make one frame; start at 36 makes a second
    @(posedge clk); #1;
    a_bus.cpol = 1'b0; a_bus.cpha = 1'b0; a_bus.cs_sel = 1'b0; a_bus.tx_data = 8'h5A;
    m_cpol = 1'b0; m_cpha = 1'b0; loop_a = 1'b1;
    @(posedge clk); #1;
    a_bus.start = 1'b1;
    t0 = cyc;
    e.rx = 128'h5A; e.srx = 8'h00; e.chk_s = 1'b0; e.cyc = t0 + 35;
    qa.push_back(e);
    for (int r = 1; r <= 37; r++) begin
      @(posedge clk); #1;
      a_bus.start = (r == 10 || r == 35 || r == 36);
      if (r == 36) begin
        e.cyc = cyc + 35;
        qa.push_back(e);
      end
      @(negedge clk);
      if (r == 36) begin
        check("a_busy_first_idle", a_bus.busy, 1'b0);
        check("a_cs_n_first_idle", cs_a, 2'b11);
      end
      if (r == 37) check("a_cs_n_second_frame", cs_a, 2'b10);
    end
    a_bus.start = 1'b0;
    repeat (40) @(posedge clk);

    // Asynchronous reset in the middle of a frame
    #1;
    a_bus.cs_sel = 1'b1; a_bus.tx_data = 8'h33; a_bus.start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    a_bus.start = 1'b0;
    while (cyc - t0 < 20) @(posedge clk);
    #1;
    check("a_midframe_busy", a_bus.busy, 1'b1);
    rst_a = 1'b1;
    #1;
    check("a_abort_cs_n", cs_a, 2'b11);
    check("a_abort_busy", a_bus.busy, 1'b0);
    check("a_abort_rx", a_bus.rx_data, 8'h00);
    check("a_abort_done", a_bus.done, 1'b0);
    check("a_abort_mosi", mosi_a, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (40) @(posedge clk);
    frame_a(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0);

    // Instance B: out-of-range select ignored, then a full AES block
    @(posedge clk); #1;
    b_bus.cs_sel = 2'd3; b_bus.tx_data = aes; b_bus.start = 1'b1;
    @(posedge clk); #1;
    b_bus.start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      check("b_badsel_busy", b_bus.busy, 1'b0);
      check("b_badsel_cs_n", cs_b, 2'b11);
    end
    @(posedge clk); #1;
    b_bus.cs_sel = 2'd0; b_bus.start = 1'b1;
    t0 = cyc;
    e.rx = aes; e.srx = 8'h00; e.chk_s = 1'b0; e.cyc = t0 + 258;
    qb.push_back(e);
    @(posedge clk); #1;
    b_bus.start = 1'b0;
    @(negedge clk);
    check("b_cs_n_cycle1", cs_b, 2'b10);
    check("b_busy_cycle1", b_bus.busy, 1'b1);
    repeat (262) @(posedge clk);
    @(negedge clk);
    check("b_busy_after", b_bus.busy, 1'b0);
    check("b_cs_n_after", cs_b, 2'b11);

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #(2_000_000);
    $display("FAIL watchdog actual=timeout required=finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
